fsm_state_monitor: RTL and testbench
====================================

# fsm_state_monitor

Passive observer for the 4-bit state bus exported by our Moore FSM blocks (`state_ref`). It samples the observed FSM's state every cycle and flags three faults: out-of-range states, transitions not in a programmable allowed-transition matrix, and a bad first state after the observed FSM's reset. Each transition is logged with its dwell time into a small trace FIFO drained over a valid/ready port. It sits beside any FSM instance in simulation and lab builds and consumes what that FSM emits.

## Interface
- `STATE_W`, 4: observed state width.
- `MIN_STATE`, 0: lowest legal state code.
- `MAX_STATE`, 15: highest legal state code.
- `RESET_STATE`, 0: required first state after the observed FSM leaves reset.
- `DWELL_W`, 16: dwell counter width, saturating.
- `TRACE_DEPTH`, 8: trace FIFO entries, power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high; clock `clk`.
- `obs_reset`, in, 1: the observed FSM's reset.
- `state_in`, in, STATE_W: observed state (`state_ref`).
- `clear`, in, 1: clear sticky errors and return to IDLE. The trace FIFO is kept.
- `allow_we`, in, 1: matrix write strobe.
- `allow_from`, `allow_to`, in, STATE_W each: matrix entry address.
- `allow_val`, in, 1: 1 = transition permitted.
- `err_range`, `err_trans`, `err_reset`, out, 1 each: sticky fault flags.
- `fault`, out, 1: OR of the three error flags.
- `dwell_max`, out, DWELL_W: longest dwell seen.
- `tr_valid`, out, 1; `tr_ready`, in, 1: trace handshake.
- `tr_from`, `tr_to`, out, STATE_W; `tr_dwell`, out, DWELL_W: head trace entry.
- `tr_overflow`, out, 1: sticky flag, a trace entry was dropped.

## Operation
- The monitor runs a Moore FSM with three states: IDLE, TRACK, FAULT.
  - IDLE: waits for `obs_reset` high. On the first cycle with `obs_reset` low, it latches `prev <= state_in`, sets `dwell = 1` and goes to TRACK. If that `state_in` ≠ RESET_STATE, it sets `err_reset`.
  - TRACK:
    - If `obs_reset` is high, go to IDLE; no error.
    - If `state_in` is outside [MIN_STATE, MAX_STATE], set `err_range`.
    - If `state_in` ≠ `prev`: push {prev, state_in, dwell} to the trace FIFO. If the matrix entry [prev][state_in] is 0, set `err_trans`. Update `dwell_max` if `dwell` > `dwell_max`. Then set `prev <= state_in` and `dwell <= 1`.
    - If `state_in` = `prev`, `dwell` increments and saturates at all-ones.
    - Any error flag set moves the FSM to FAULT.
  - FAULT: keeps tracking and logging exactly as in TRACK; errors stay latched. `clear` → IDLE.
- `clear` has priority over every transition. In IDLE, `clear` is a no-op.
- Allowed-transition matrix: 2^STATE_W × 2^STATE_W bits, reset value all ones (permit all). A write takes effect on the next cycle's check. A write in the same cycle as a check on that same entry uses the old value.
- A self-transition is never checked and never logged.

## Timing
- Error flags, `fault` and `dwell_max` update one cycle after the offending `state_in` sample.
- A trace entry becomes visible on `tr_*` one cycle after its push; `tr_valid` rises then.
- A pop happens on `tr_valid && tr_ready`. The next entry, or `tr_valid` = 0, appears the following cycle.
- FIFO full and push with no pop: the new entry is dropped, older entries are kept, and `tr_overflow` is set.
- FIFO full with push and pop in the same cycle: both succeed; no overflow.
- FIFO empty with push and `tr_ready` high: the entry is not popped in that same cycle.
- Pointer wrap-around is modulo TRACE_DEPTH, with an extra MSB to distinguish full from empty.
- Reset values:
  - FSM = IDLE; all error flags = 0; `fault` = 0.
  - `dwell_max` = 0; `tr_valid` = 0; `tr_from`, `tr_to`, `tr_dwell` = 0; `tr_overflow` = 0.
  - Matrix = all ones; FIFO empty.
- `reset` in mid-operation discards the FIFO contents and the matrix immediately, on that clock edge.

## Configuration
- `FSM_MON_TRACE_EN`:
  - Defined: the trace FIFO, `tr_*` handshake and `tr_overflow` are built.
  - Undefined: no FIFO storage; `tr_valid` = 0, `tr_from`/`tr_to`/`tr_dwell` = 0 and `tr_overflow` = 0 constantly, and `tr_ready` is ignored. All error detection and `dwell_max` behave identically either way.

## Test plan
- Reset, then `obs_reset` 1→0 with `state_in` = 3 and RESET_STATE = 0 → `err_reset` = 1 and `fault` = 1 next cycle; FSM in FAULT; no trace entry.
- Matrix cleared for [0][2] only; states 0 (5 cycles) → 2 → entry {0, 2, 5} on `tr_*`, `err_trans` = 1, `dwell_max` = 5.
- MAX_STATE = 9, `state_in` = 12 → `err_range` = 1; pulse `clear` → all flags 0, FSM in IDLE.
- TRACE_DEPTH = 8, `tr_ready` = 0, 9 transitions → first 8 entries retained in order, 9th dropped, `tr_overflow` = 1. Next transition with `tr_ready` = 1 while full → pop and push both succeed, overflow unchanged.
- Hold one state for 2^DWELL_W + 3 cycles, then transition → `tr_dwell` = all ones (saturated).
- Build without `FSM_MON_TRACE_EN`, run scenario 2 → `tr_valid` stays 0; `err_trans` and `dwell_max` identical to scenario 2.

Source files
------------

// File: rtl/fsm_state_monitor.sv
// fsm_state_monitor: passive observer for a Moore FSM state bus.
// Flags out-of-range states, disallowed transitions and a bad first state
// after the observed FSM leaves reset. Every transition is logged with its
// dwell time into a trace FIFO drained over a valid/ready port.
// Optional feature macro: FSM_MON_TRACE_EN builds the trace FIFO; without it
// the tr_* outputs are tied to zero and tr_ready is ignored.
module fsm_state_monitor #(
   parameter int STATE_W     = 4,
   parameter int MIN_STATE   = 0,
   parameter int MAX_STATE   = 15,
   parameter int RESET_STATE = 0,
   parameter int DWELL_W     = 16,
   parameter int TRACE_DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               obs_reset,
   input  logic [STATE_W-1:0] state_in,
   input  logic               clear,
   input  logic               allow_we,
   input  logic [STATE_W-1:0] allow_from,
   input  logic [STATE_W-1:0] allow_to,
   input  logic               allow_val,
   output logic               err_range,
   output logic               err_trans,
   output logic               err_reset,
   output logic               fault,
   output logic [DWELL_W-1:0] dwell_max,
   output logic               tr_valid,
   input  logic               tr_ready,
   output logic [STATE_W-1:0] tr_from,
   output logic [STATE_W-1:0] tr_to,
   output logic [DWELL_W-1:0] tr_dwell,
   output logic               tr_overflow
);

   localparam int NSTATES = 2 ** STATE_W;
   localparam int ENTRY_W = 2 * STATE_W + DWELL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

   mon_state_t state, state_nxt;

   logic [NSTATES*NSTATES-1:0] allow_mat;
   logic [STATE_W-1:0]         prev;
   logic [DWELL_W-1:0]         dwell;
   logic                       armed;

   logic start, active, changed, range_bad;
   logic range_hit, trans_hit, reset_hit;
   logic err_range_nxt, err_trans_nxt, err_reset_nxt, any_err_nxt;
   logic push;
   logic [ENTRY_W-1:0] push_data;

   assign push_data = {prev, state_in, dwell};
   assign fault     = err_range | err_trans | err_reset;

   // Next-state logic and per-sample fault detection; clear overrides everything.
   always_comb begin
      start         = 1'b0;
      active        = 1'b0;
      changed       = 1'b0;
      range_bad     = 1'b0;
      range_hit     = 1'b0;
      trans_hit     = 1'b0;
      reset_hit     = 1'b0;
      push          = 1'b0;
      err_range_nxt = err_range;
      err_trans_nxt = err_trans;
      err_reset_nxt = err_reset;
      any_err_nxt   = 1'b0;
      state_nxt     = state;

      start     = (state == IDLE) && armed && !obs_reset && !clear;
      active    = (state != IDLE) && !obs_reset && !clear;
      changed   = (state_in != prev);
      range_bad = (int'(state_in) < MIN_STATE) || (int'(state_in) > MAX_STATE);

      range_hit = active && range_bad;
      trans_hit = active && changed && !allow_mat[{prev, state_in}];
      reset_hit = start && (state_in != STATE_W'(RESET_STATE));
      push      = active && changed;

      if (clear) begin
         err_range_nxt = 1'b0;
         err_trans_nxt = 1'b0;
         err_reset_nxt = 1'b0;
      end else begin
         err_range_nxt = err_range | range_hit;
         err_trans_nxt = err_trans | trans_hit;
         err_reset_nxt = err_reset | reset_hit;
      end
      any_err_nxt = err_range_nxt | err_trans_nxt | err_reset_nxt;

      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = any_err_nxt ? FAULT : TRACK;
            TRACK:   if (obs_reset) state_nxt = IDLE;
                     else if (any_err_nxt) state_nxt = FAULT;
            FAULT:   if (obs_reset) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Monitor FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Sticky fault flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_range <= 1'b0;
         err_trans <= 1'b0;
         err_reset <= 1'b0;
      end else begin
         err_range <= err_range_nxt;
         err_trans <= err_trans_nxt;
         err_reset <= err_reset_nxt;
      end
   end

   // IDLE only starts tracking after it has seen the observed FSM in reset.
   always_ff @(posedge clk) begin
      if (reset)          armed <= 1'b0;
      else if (obs_reset) armed <= 1'b1;
      else if (start)     armed <= 1'b0;
   end

   // Previous state and saturating dwell counter of the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev  <= '0;
         dwell <= '0;
      end else if (start || (active && changed)) begin
         prev  <= state_in;
         dwell <= DWELL_W'(1);
      end else if (active && (dwell != {DWELL_W{1'b1}})) begin
         dwell <= dwell + 1'b1;
      end
   end

   // Longest dwell seen, sampled at each logged transition.
   always_ff @(posedge clk) begin
      if (reset)                        dwell_max <= '0;
      else if (push && dwell > dwell_max) dwell_max <= dwell;
   end

   // Allowed-transition matrix; reads in the same cycle see the old value.
   always_ff @(posedge clk) begin
      if (reset)         allow_mat <= '1;
      else if (allow_we) allow_mat[{allow_from, allow_to}] <= allow_val;
   end

`ifdef FSM_MON_TRACE_EN
   localparam int AW = $clog2(TRACE_DEPTH);

   logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               fifo_empty, fifo_full, pop, push_ok, overflow_q;
   logic [ENTRY_W-1:0] head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !fifo_empty && tr_ready;
   assign push_ok    = push && (!fifo_full || pop);
   assign head       = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

   assign tr_valid    = !fifo_empty;
   assign tr_from     = head[ENTRY_W-1 -: STATE_W];
   assign tr_to       = head[DWELL_W +: STATE_W];
   assign tr_dwell    = head[DWELL_W-1:0];
   assign tr_overflow = overflow_q;

   // Trace FIFO pointers and sticky overflow; a full FIFO drops the new entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push && fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   // Trace FIFO storage; emptiness is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end
`else
   localparam int TRACE_DEPTH_UNUSED = TRACE_DEPTH;

   logic trace_unused;

   assign trace_unused = ^{tr_ready, push, push_data, TRACE_DEPTH_UNUSED[0]};
   assign tr_valid     = 1'b0;
   assign tr_from      = '0;
   assign tr_to        = '0;
   assign tr_dwell     = '0;
   assign tr_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_state_monitor.sv
// tb_fsm_state_monitor: directed self-checking bench for fsm_state_monitor.
// Trace expectations follow FSM_MON_TRACE_EN; when it is undefined the tr_*
// outputs are expected to stay at zero while fault checks are unchanged.
module tb_fsm_state_monitor;

`ifdef FSM_MON_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, obs_reset, clear, allow_we, allow_val, tr_ready;
   logic [3:0]  state_in, allow_from, allow_to;
   logic        err_range, err_trans, err_reset, fault, tr_valid, tr_overflow;
   logic [15:0] dwell_max, tr_dwell;
   logic [3:0]  tr_from, tr_to;

   int total = 0;
   int bad   = 0;

   fsm_state_monitor #(
      .STATE_W(4), .MIN_STATE(0), .MAX_STATE(9), .RESET_STATE(0),
      .DWELL_W(16), .TRACE_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset), .obs_reset(obs_reset), .state_in(state_in),
      .clear(clear), .allow_we(allow_we), .allow_from(allow_from),
      .allow_to(allow_to), .allow_val(allow_val),
      .err_range(err_range), .err_trans(err_trans), .err_reset(err_reset),
      .fault(fault), .dwell_max(dwell_max),
      .tr_valid(tr_valid), .tr_ready(tr_ready),
      .tr_from(tr_from), .tr_to(tr_to), .tr_dwell(tr_dwell),
      .tr_overflow(tr_overflow)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkHead(input string tag, input int f, input int t, input int d);
      checkOutput({tag, " tr_valid"}, 32'(tr_valid), TRACE ? 32'd1 : 32'd0);
      checkOutput({tag, " tr_from"},  32'(tr_from),  TRACE ? 32'(f) : 32'd0);
      checkOutput({tag, " tr_to"},    32'(tr_to),    TRACE ? 32'(t) : 32'd0);
      if (d >= 0)
         checkOutput({tag, " tr_dwell"}, 32'(tr_dwell), TRACE ? 32'(d) : 32'd0);
   endtask

   // Directed scenario sequence.
   initial begin
      int exp_from [8];
      int exp_to [8];
      exp_from = '{1, 2, 3, 4, 5, 6, 7, 9};
      exp_to   = '{2, 3, 4, 5, 6, 7, 8, 3};

      reset = 1'b1; obs_reset = 1'b0; clear = 1'b0; allow_we = 1'b0; allow_val = 1'b0;
      tr_ready = 1'b0; state_in = 4'd0; allow_from = 4'd0; allow_to = 4'd0;
      $display("[TB] reset values");
      applyStimulus(2);
      checkOutput("rst err_range", 32'(err_range), 32'd0);
      checkOutput("rst err_trans", 32'(err_trans), 32'd0);
      checkOutput("rst err_reset", 32'(err_reset), 32'd0);
      checkOutput("rst fault", 32'(fault), 32'd0);
      checkOutput("rst dwell_max", 32'(dwell_max), 32'd0);
      checkOutput("rst tr_valid", 32'(tr_valid), 32'd0);
      checkOutput("rst tr_entry", 32'({tr_from, tr_to, tr_dwell}), 32'd0);
      checkOutput("rst tr_overflow", 32'(tr_overflow), 32'd0);
      checkOutput("rst fsm", 32'(dut.state), 32'd0);

      $display("[TB] bad first state after observed reset");
      reset = 1'b0; obs_reset = 1'b1;
      applyStimulus(1);
      obs_reset = 1'b0; state_in = 4'd3;
      applyStimulus(1);
      checkOutput("s1 err_reset", 32'(err_reset), 32'd1);
      checkOutput("s1 fault", 32'(fault), 32'd1);
      checkOutput("s1 fsm", 32'(dut.state), 32'd2);
      checkOutput("s1 tr_valid", 32'(tr_valid), 32'd0);
      applyStimulus(2);
      checkOutput("s1 sticky", 32'(err_reset), 32'd1);
      clear = 1'b1;
      applyStimulus(1);
      clear = 1'b0;
      checkOutput("s1 clear fault", 32'(fault), 32'd0);
      checkOutput("s1 clear fsm", 32'(dut.state), 32'd0);

      $display("[TB] disallowed transition 0->2");
      allow_we = 1'b1; allow_from = 4'd0; allow_to = 4'd2; allow_val = 1'b0;
      applyStimulus(1);
      allow_we = 1'b0;
      obs_reset = 1'b1;
      applyStimulus(1);
      obs_reset = 1'b0; state_in = 4'd0;
      applyStimulus(1);
      checkOutput("s2 err_reset", 32'(err_reset), 32'd0);
      checkOutput("s2 fsm", 32'(dut.state), 32'd1);
      applyStimulus(4);
      state_in = 4'd2;
      applyStimulus(1);
      checkOutput("s2 err_trans", 32'(err_trans), 32'd1);
      checkOutput("s2 dwell_max", 32'(dwell_max), 32'd5);
      checkHead("s2 head", 0, 2, 5);
      tr_ready = 1'b1;
      applyStimulus(1);
      tr_ready = 1'b0;
      checkOutput("s2 popped", 32'(tr_valid), 32'd0);

      $display("[TB] out-of-range state and clear");
      state_in = 4'd12;
      applyStimulus(1);
      checkOutput("s3 err_range", 32'(err_range), 32'd1);
      checkOutput("s3 fault", 32'(fault), 32'd1);
      clear = 1'b1;
      applyStimulus(1);
      clear = 1'b0;
      checkOutput("s3 flags", 32'({err_range, err_trans, err_reset, fault}), 32'd0);
      checkOutput("s3 fsm", 32'(dut.state), 32'd0);
      checkHead("s3 kept", 2, 12, 2);
      tr_ready = 1'b1;
      applyStimulus(1);
      tr_ready = 1'b0;

      $display("[TB] trace overflow and full push+pop");
      obs_reset = 1'b1;
      applyStimulus(1);
      obs_reset = 1'b0; state_in = 4'd0;
      applyStimulus(1);
      for (int s = 1; s <= 9; s++) begin
         state_in = 4'(s);
         applyStimulus(1);
      end
      checkOutput("s4 fault", 32'(fault), 32'd0);
      checkOutput("s4 overflow", 32'(tr_overflow), TRACE ? 32'd1 : 32'd0);
      checkHead("s4 head", 0, 1, 1);
      tr_ready = 1'b1; state_in = 4'd3;
      applyStimulus(1);
      checkOutput("s4 overflow kept", 32'(tr_overflow), TRACE ? 32'd1 : 32'd0);
      for (int i = 0; i < 8; i++) begin
         checkHead($sformatf("s4 entry%0d", i), exp_from[i], exp_to[i], 1);
         applyStimulus(1);
      end
      checkOutput("s4 drained", 32'(tr_valid), 32'd0);
      state_in = 4'd4;
      applyStimulus(1);
      checkHead("s4 no same-cycle pop", 3, 4, 9);
      checkOutput("s4 dwell_max", 32'(dwell_max), 32'd9);
      applyStimulus(1);
      tr_ready = 1'b0;
      checkOutput("s4 popped", 32'(tr_valid), 32'd0);

      $display("[TB] dwell saturation");
      applyStimulus(65539);
      state_in = 4'd5;
      applyStimulus(1);
      checkHead("s5 head", 4, 5, 16'hFFFF);
      checkOutput("s5 dwell_max", 32'(dwell_max), 32'h0000FFFF);
      tr_ready = 1'b1;
      applyStimulus(1);
      tr_ready = 1'b0;

      $display("[TB] matrix write timing");
      state_in = 4'd6; allow_we = 1'b1; allow_from = 4'd5; allow_to = 4'd6; allow_val = 1'b0;
      applyStimulus(1);
      allow_we = 1'b0;
      checkOutput("s6 old value used", 32'(err_trans), 32'd0);
      state_in = 4'd5;
      applyStimulus(1);
      state_in = 4'd6;
      applyStimulus(1);
      checkOutput("s6 new value used", 32'(err_trans), 32'd1);
      checkOutput("s6 fsm", 32'(dut.state), 32'd2);

      $display("[TB] mid-operation reset");
      reset = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      checkOutput("s7 flags", 32'({err_range, err_trans, err_reset, fault}), 32'd0);
      checkOutput("s7 tr_valid", 32'(tr_valid), 32'd0);
      checkOutput("s7 dwell_max", 32'(dwell_max), 32'd0);
      obs_reset = 1'b1;
      applyStimulus(1);
      obs_reset = 1'b0; state_in = 4'd0;
      applyStimulus(1);
      state_in = 4'd2;
      applyStimulus(1);
      checkOutput("s7 matrix reset", 32'(err_trans), 32'd0);
      checkHead("s7 head", 0, 2, 1);
      obs_reset = 1'b1;
      applyStimulus(1);
      checkOutput("s7 obs_reset idle", 32'(dut.state), 32'd0);
      checkOutput("s7 obs_reset fault", 32'(fault), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
